// File: rtl/contador_regresivo_ms_if.sv
// -----------------------------------------------------------------------------
// contador_regresivo_ms_if
//   Control/status bundle of the millisecond countdown timer.
//
//   Control handshake: there is no valid/ready pair. LOAD, START and STOP are
//   level commands sampled on every rising CLK edge; whoever drives them keeps
//   each high for exactly the edges it should act on. Status outputs are
//   registered and can be sampled at any time away from the edge.
//
//   Signals
//     LOAD   master->slave  capture VALUE into Q, return to IDLE
//     VALUE  master->slave  16-bit initial count in ms
//     START  master->slave  begin / resume counting
//     STOP   master->slave  pause counting
//     Q      slave->master  remaining ms
//     BUSY   slave->master  high in RUN or PAUSE
//     TICK   slave->master  one-cycle pulse on each Q decrement
//     DONE   slave->master  one-cycle pulse on expiry
// -----------------------------------------------------------------------------
interface contador_regresivo_ms_if;
   logic        LOAD;
   logic [15:0] VALUE;
   logic        START;
   logic        STOP;
   logic [15:0] Q;
   logic        BUSY;
   logic        TICK;
   logic        DONE;

   modport master (
      output LOAD, VALUE, START, STOP,
      input  Q, BUSY, TICK, DONE
   );

   modport slave (
      input  LOAD, VALUE, START, STOP,
      output Q, BUSY, TICK, DONE
   );
endinterface

// File: rtl/contador_regresivo_ms.sv
// -----------------------------------------------------------------------------
// contador_regresivo_ms
//   Millisecond countdown timer. A 16-bit ms value is loaded, then decremented
//   once per internal prescaler tick (CLK_FREQ_HZ/TICK_HZ cycles, must be >= 2).
//   Expiry produces a one-cycle DONE pulse together with the final TICK.
//
//   Parameters
//     CLK_FREQ_HZ  CLK frequency in Hz
//     TICK_HZ      decrement rate in Hz
//
//   Ports
//     CLK        system clock, all logic on posedge
//     RST        synchronous active-high reset
//     bus        contador_regresivo_ms_if.slave (LOAD/VALUE/START/STOP in,
//                Q/BUSY/TICK/DONE out)
//     state_dbg  current FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//
//   Build option
//     AUTO_RELOAD_EN  when defined, LOAD also stores VALUE in a reload register
//                     and a terminal tick reloads Q and keeps running (unless
//                     the reload value is 0).
// -----------------------------------------------------------------------------
module contador_regresivo_ms #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1000
) (
   input  logic                     CLK,
   input  logic                     RST,
   contador_regresivo_ms_if.slave   bus,
   output logic [1:0]               state_dbg
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [15:0]   q_r;
   logic          tick_r;
   logic          done_r;
`ifdef AUTO_RELOAD_EN
   logic [15:0]   reload_r;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         presc  <= '0;
         q_r    <= '0;
         tick_r <= 1'b0;
         done_r <= 1'b0;
`ifdef AUTO_RELOAD_EN
         reload_r <= '0;
`endif
      end else begin
         tick_r <= 1'b0;
         done_r <= 1'b0;

         if (bus.LOAD) begin
            q_r   <= bus.VALUE;
            presc <= '0;
            state <= IDLE;
`ifdef AUTO_RELOAD_EN
            reload_r <= bus.VALUE;
`endif
         end else if (bus.STOP) begin
            // STOP outranks START; it only matters in RUN. Prescaler and Q
            // hold, so a tick pending on this edge is deferred, not lost.
            if (state == RUN) begin
               state <= PAUSE;
            end
         end else if (state == IDLE) begin
            if (bus.START && (q_r != 16'd0)) begin
               state <= RUN;
               presc <= '0;
            end
         end else if ((state == PAUSE) && !bus.START) begin
            // paused: hold everything
         end else begin
            // RUN, or PAUSE being resumed. The resume edge already counts as
            // a running cycle, so the partial millisecond continues seamlessly.
            state <= RUN;
            if (presc == PRESC_LAST) begin
               presc  <= '0;
               tick_r <= 1'b1;
               if (q_r <= 16'd1) begin
                  done_r <= 1'b1;
`ifdef AUTO_RELOAD_EN
                  if (reload_r != 16'd0) begin
                     q_r <= reload_r;
                  end else begin
                     q_r   <= 16'd0;
                     state <= IDLE;
                  end
`else
                  q_r   <= 16'd0;
                  state <= IDLE;
`endif
               end else begin
                  q_r <= q_r - 16'd1;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

   assign bus.Q     = q_r;
   assign bus.BUSY  = (state != IDLE);
   assign bus.TICK  = tick_r;
   assign bus.DONE  = done_r;
   assign state_dbg = state;

endmodule
